// File: rtl/audio_i2s_tx.sv
// I2S (or left-justified) DAC serializer with a one-frame holding buffer and sticky underrun flag.
// Define I2S_TX_LEFT_JUSTIFIED_EN to drop the one-bit MSB delay and emit left-justified frames.
module audio_i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic                clk_24m,
  input  logic                reset_,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic                frame_strobe,
  output logic                audio_mclk,
  output logic                audio_bclk,
  output logic                audio_daclrc,
  output logic                audio_dacdat
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int ALIGN = SLOT_W - SAMPLE_W;
`else
  localparam int ALIGN = SLOT_W - SAMPLE_W - 1;
`endif
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

  logic [DW-1:0]       div_cnt, div_nxt;
  logic [BW-1:0]       bit_cnt, bit_nxt, pos_nxt;
  logic                mclk_q, bclk_q, lrc_q, dat_q, dat_nxt;
  logic                fall_evt, frame_load, accept;
  logic [SAMPLE_W-1:0] buf_l, buf_r, frame_l, frame_r, frame_l_nxt, frame_r_nxt;
  logic                buf_full, armed, underrun_q, strobe_q;

  // The sample is placed in a slot-wide word at its justified offset, then shifted so position p lands on the MSB.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input logic [BW-1:0] p);
    logic [SLOT_W-1:0] v;
    v = SLOT_W'(s) << ALIGN;
    v = v << p;
    return v[SLOT_W-1];
  endfunction

  always_comb begin
    fall_evt    = (div_cnt == DIV_LAST);
    frame_load  = fall_evt && (bit_cnt == BIT_LAST);
    div_nxt     = fall_evt ? '0 : div_cnt + 1'b1;
    bit_nxt     = frame_load ? '0 : bit_cnt + 1'b1;
    accept      = sample_valid && !buf_full;
    frame_l_nxt = (frame_load && buf_full) ? buf_l : frame_l;
    frame_r_nxt = (frame_load && buf_full) ? buf_r : frame_r;
    pos_nxt     = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
    dat_nxt     = slot_bit((bit_nxt >= SLOT_LEN) ? frame_r_nxt : frame_l_nxt, pos_nxt);
  end

  // bclk is registered from the next divider value so it always matches div_cnt without decode glitches.
  always_ff @(posedge clk_24m or negedge reset_) begin
    if (!reset_) begin
      mclk_q  <= 1'b0;
      div_cnt <= '0;
      bclk_q  <= 1'b0;
    end else begin
      mclk_q  <= ~mclk_q;
      div_cnt <= div_nxt;
      bclk_q  <= (div_nxt >= DIV_HALF);
    end
  end

  always_ff @(posedge clk_24m or negedge reset_) begin
    if (!reset_) begin
      bit_cnt  <= '0;
      lrc_q    <= 1'b0;
      dat_q    <= 1'b0;
      frame_l  <= '0;
      frame_r  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= frame_load;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrc_q   <= (bit_nxt >= SLOT_LEN);
        dat_q   <= dat_nxt;
        frame_l <= frame_l_nxt;
        frame_r <= frame_r_nxt;
      end
    end
  end

  // A load always sees the buffer as it was before this cycle's accept, so a coincident accept waits a frame.
  always_ff @(posedge clk_24m or negedge reset_) begin
    if (!reset_) begin
      buf_l      <= '0;
      buf_r      <= '0;
      buf_full   <= 1'b0;
      armed      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (frame_load && buf_full) begin
        buf_full <= 1'b0;
      end
      if (accept) begin
        buf_l    <= sample_l;
        buf_r    <= sample_r;
        buf_full <= 1'b1;
        armed    <= 1'b1;
      end
      if (frame_load && !buf_full && armed) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign sample_ready = ~buf_full;
  assign underrun     = underrun_q;
  assign frame_strobe = strobe_q;
  assign audio_mclk   = mclk_q;
  assign audio_bclk   = bclk_q;
  assign audio_daclrc = lrc_q;
  assign audio_dacdat = dat_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: frame-level reference model plus directed literal checks.
// Honours I2S_TX_LEFT_JUSTIFIED_EN for the expected bit mapping.
module tb_audio_i2s_tx;

  localparam int SW    = 16;
  localparam int SL    = 32;
  localparam int DIV   = 8;
  localparam int FRAME = 2 * SL * DIV;

  logic          clk_24m = 1'b0;
  logic          reset_;
  logic [SW-1:0] sample_l, sample_r;
  logic          sample_valid, underrun_clr;
  logic          sample_ready, underrun, frame_strobe;
  logic          audio_mclk, audio_bclk, audio_daclrc, audio_dacdat;

  int compared   = 0;
  int mismatched = 0;

  audio_i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(DIV)) dut (
    .clk_24m(clk_24m), .reset_(reset_),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .underrun_clr(underrun_clr), .underrun(underrun),
    .frame_strobe(frame_strobe), .audio_mclk(audio_mclk), .audio_bclk(audio_bclk),
    .audio_daclrc(audio_daclrc), .audio_dacdat(audio_dacdat)
  );

  always #5 clk_24m = ~clk_24m;

  // Reference model: time since reset plus frame/buffer contents; outputs derived arithmetically.
  int            m_t     = 0;
  logic          m_full  = 1'b0;
  logic          m_armed = 1'b0;
  logic          m_under = 1'b0;
  logic [SW-1:0] m_bl = '0, m_br = '0, m_fl = '0, m_fr = '0;

  always @(posedge clk_24m or negedge reset_) begin
    if (!reset_) begin
      m_t = 0; m_full = 1'b0; m_armed = 1'b0; m_under = 1'b0;
      m_bl = '0; m_br = '0; m_fl = '0; m_fr = '0;
    end else begin
      logic was_full, set_now;
      was_full = m_full;
      set_now  = 1'b0;
      if ((m_t + 1) % FRAME == 0) begin
        if (was_full) begin
          m_fl = m_bl; m_fr = m_br; m_full = 1'b0;
        end else if (m_armed) begin
          set_now = 1'b1;
        end
      end
      if (sample_valid && !was_full) begin
        m_bl = sample_l; m_br = sample_r; m_full = 1'b1; m_armed = 1'b1;
      end
      if (set_now) m_under = 1'b1;
      else if (underrun_clr) m_under = 1'b0;
      m_t = m_t + 1;
    end
  end

  function automatic logic [6:0] model_vec();
    int b, p;
    logic [SW-1:0] s, sh;
    logic d;
    b = (m_t / DIV) % (2 * SL);
    p = b % SL;
    s = (b >= SL) ? m_fr : m_fl;
    d = 1'b0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    if (p < SW) begin sh = s >> (SW - 1 - p); d = sh[0]; end
`else
    if (p >= 1 && p <= SW) begin sh = s >> (SW - p); d = sh[0]; end
`endif
    return {!m_full, m_under, (m_t > 0 && m_t % FRAME == 0), (m_t % 2 == 1),
            ((m_t % DIV) >= DIV / 2), (b >= SL), d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_24m) begin
    checkOutput("outputs", 32'({sample_ready, underrun, frame_strobe, audio_mclk,
                                audio_bclk, audio_daclrc, audio_dacdat}), 32'(model_vec()));
  end

  task automatic waitStrobe(output int cycles);
    cycles = 0;
    while (!frame_strobe && cycles < 2 * FRAME) begin
      @(negedge clk_24m);
      cycles++;
    end
    if (!frame_strobe) checkOutput("strobe_timeout", 32'(cycles), 32'(FRAME));
  endtask

  task automatic captureFrame(output logic [31:0] lw, output logic [31:0] rw);
    logic [63:0] fb;
    repeat (DIV / 2) @(negedge clk_24m);
    for (int b = 0; b < 2 * SL; b++) begin
      fb[63 - b] = audio_dacdat;
      if (b < 2 * SL - 1) repeat (DIV) @(negedge clk_24m);
    end
    lw = fb[63:32];
    rw = fb[31:0];
  endtask

  task automatic applyStimulus(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 2 * FRAME) begin
      @(negedge clk_24m);
      n++;
    end
    if (!sample_ready) checkOutput("accept_timeout", 32'(n), 32'(FRAME));
    @(negedge clk_24m);
    sample_valid = 1'b0;
  endtask

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam logic [31:0] SLOT_A55A = 32'hA55A0000;
  localparam logic [31:0] SLOT_8001 = 32'h80010000;
  localparam logic [31:0] SLOT_1234 = 32'h12340000;
  localparam logic [31:0] SLOT_FEDC = 32'hFEDC0000;
`else
  localparam logic [31:0] SLOT_A55A = 32'h52AD0000;
  localparam logic [31:0] SLOT_8001 = 32'h40008000;
  localparam logic [31:0] SLOT_1234 = 32'h091A0000;
  localparam logic [31:0] SLOT_FEDC = 32'h7F6E0000;
`endif

  initial begin
    int cyc, acc;
    logic upd;
    logic [31:0] lw, rw;
    reset_ = 1'b0; sample_l = '0; sample_r = '0; sample_valid = 1'b0; underrun_clr = 1'b0;
    repeat (10) @(negedge clk_24m);
    checkOutput("reset_values", 32'({sample_ready, underrun, frame_strobe, audio_mclk,
                                     audio_bclk, audio_daclrc, audio_dacdat}), 32'h40);
    reset_ = 1'b1;

    $display("[TB] pre-arm frames");
    waitStrobe(cyc);
    checkOutput("first_strobe_cycle", 32'(cyc), 32'(FRAME));
    captureFrame(lw, rw);
    checkOutput("prearm_left", lw, 32'h0);
    checkOutput("prearm_right", rw, 32'h0);
    waitStrobe(cyc);
    @(negedge clk_24m);
    waitStrobe(cyc);
    checkOutput("prearm_underrun", 32'(underrun), 32'h0);

    $display("[TB] single frame");
    applyStimulus(16'hA55A, 16'h8001);
    waitStrobe(cyc);
    checkOutput("single_underrun", 32'(underrun), 32'h0);
    captureFrame(lw, rw);
    checkOutput("single_left", lw, SLOT_A55A);
    checkOutput("single_right", rw, SLOT_8001);

    $display("[TB] underrun");
    waitStrobe(cyc);
    checkOutput("underrun_set", 32'(underrun), 32'h1);
    captureFrame(lw, rw);
    checkOutput("repeat_left", lw, SLOT_A55A);
    checkOutput("repeat_right", rw, SLOT_8001);
    @(negedge clk_24m);
    underrun_clr = 1'b1;
    @(negedge clk_24m);
    underrun_clr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'h0);

    $display("[TB] continuous valid");
    waitStrobe(cyc);
    acc = 0; upd = 1'b0;
    sample_l = 16'h1000; sample_r = 16'h2000; sample_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (sample_valid && sample_ready) begin acc++; upd = 1'b1; end
      @(negedge clk_24m);
      if (upd) begin sample_l = sample_l + 16'h0111; sample_r = sample_r - 16'h0333; upd = 1'b0; end
    end
    sample_valid = 1'b0;
    checkOutput("accepts_in_3_frames", 32'(acc), 32'd3);

    $display("[TB] accept and clear coincident with empty load");
    repeat (FRAME - 1) @(negedge clk_24m);
    sample_l = 16'h1234; sample_r = 16'hFEDC; sample_valid = 1'b1; underrun_clr = 1'b1;
    @(negedge clk_24m);
    sample_valid = 1'b0; underrun_clr = 1'b0;
    checkOutput("underrun_set_wins", 32'(underrun), 32'h1);
    checkOutput("ready_after_coincident", 32'(sample_ready), 32'h0);
    captureFrame(lw, rw);
    waitStrobe(cyc);
    captureFrame(lw, rw);
    checkOutput("coincident_left", lw, SLOT_1234);
    checkOutput("coincident_right", rw, SLOT_FEDC);

    $display("[TB] mid-frame reset");
    waitStrobe(cyc);
    repeat (20 * DIV + 3) @(negedge clk_24m);
    #2 reset_ = 1'b0;
    #1 checkOutput("mid_reset_values", 32'({sample_ready, underrun, frame_strobe, audio_mclk,
                                            audio_bclk, audio_daclrc, audio_dacdat}), 32'h40);
    repeat (5) @(negedge clk_24m);
    reset_ = 1'b1;
    waitStrobe(cyc);
    checkOutput("restart_strobe_cycle", 32'(cyc), 32'(FRAME));
    repeat (40) @(negedge clk_24m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
